// File: rtl/ysyx_23060229_exu_alu_stage.sv
// Execute-stage ALU slot: RV32I integer ALU between IDU and WBU/LSU.
// Result and rd tag are held in output registers until downstream drains.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   flush             synchronous pipeline flush, dominates all inputs
//   in_valid/ready    upstream handshake; in_ready allows accept-while-draining
//   op, src1, src2    ALU op (0..10, 11..15 reserved -> 0) and operands
//   rd                destination register tag
//   out_valid/ready   downstream handshake
//   result, out_rd    registered ALU result and rd tag
//
// Build option: YSYX_23060229_EXU_SERIAL_SHIFT_EN selects a 1-bit-per-cycle
// shifter for SLL/SRL/SRA instead of the barrel shifter.

module ysyx_23060229_exu_alu_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [RD_W-1:0] rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] out_rd
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_SLL   = 4'd2;
  localparam logic [3:0] OP_SLT   = 4'd3;
  localparam logic [3:0] OP_SLTU  = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_AND   = 4'd9;
  localparam logic [3:0] OP_PASS2 = 4'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
`ifdef YSYX_23060229_EXU_SERIAL_SHIFT_EN
    SHIFT = 2'd1,
`endif
    HOLD  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] result_q, result_d;
  logic [RD_W-1:0] rd_q, rd_d;

  logic [4:0]      shamt;
  logic            accept;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] alu_res;

  assign shamt     = src2[4:0];
  assign in_ready  = (state_q == IDLE) ||
                     ((state_q == HOLD) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign out_rd    = rd_q;

  assign lt_s = $signed(src1) < $signed(src2);
  assign lt_u = src1 < src2;

`ifdef YSYX_23060229_EXU_SERIAL_SHIFT_EN
  logic [XLEN-1:0] work_q, work_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [3:0]      sop_q, sop_d;
  logic [RD_W-1:0] srd_q, srd_d;
  logic [XLEN-1:0] step;
  logic            is_shift;
  logic            start_ser;

  assign is_shift  = (op == OP_SLL) || (op == OP_SRL) ||
                     (op == OP_SRA);
  assign start_ser = is_shift && (shamt != 5'd0);

  always_comb begin
    step = work_q;
    unique case (sop_q)
      OP_SLL:  step = {work_q[XLEN-2:0], 1'b0};
      OP_SRL:  step = {1'b0, work_q[XLEN-1:1]};
      OP_SRA:  step = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: step = work_q;
    endcase
  end
`endif

  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:   alu_res = src1 + src2;
      OP_SUB:   alu_res = src1 - src2;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:   alu_res = src1 ^ src2;
      OP_OR:    alu_res = src1 | src2;
      OP_AND:   alu_res = src1 & src2;
      OP_PASS2: alu_res = src2;
`ifdef YSYX_23060229_EXU_SERIAL_SHIFT_EN
      // Only shamt==0 shifts finish here; nonzero go serial.
      OP_SLL:   alu_res = src1;
      OP_SRL:   alu_res = src1;
      OP_SRA:   alu_res = src1;
`else
      OP_SLL:   alu_res = src1 << shamt;
      OP_SRL:   alu_res = src1 >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(src1) >>> shamt);
`endif
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rd_d     = rd_q;
`ifdef YSYX_23060229_EXU_SERIAL_SHIFT_EN
    work_d   = work_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    srd_d    = srd_q;
`endif
    unique case (state_q)
      IDLE, HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (accept) begin
`ifdef YSYX_23060229_EXU_SERIAL_SHIFT_EN
          if (start_ser) begin
            work_d  = src1;
            cnt_d   = shamt;
            sop_d   = op;
            srd_d   = rd;
            state_d = SHIFT;
          end else begin
            result_d = alu_res;
            rd_d     = rd;
            state_d  = HOLD;
          end
`else
          result_d = alu_res;
          rd_d     = rd;
          state_d  = HOLD;
`endif
        end else if ((state_q == HOLD) && out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef YSYX_23060229_EXU_SERIAL_SHIFT_EN
      SHIFT: begin
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q != 5'd0) begin
          work_d = step;
          cnt_d  = cnt_q - 5'd1;
        end else begin
          result_d = work_q;
          rd_d     = srd_q;
          state_d  = HOLD;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rd_q     <= rd_d;
    end
  end

`ifdef YSYX_23060229_EXU_SERIAL_SHIFT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      cnt_q  <= '0;
      sop_q  <= '0;
      srd_q  <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      sop_q  <= sop_d;
      srd_q  <= srd_d;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060229_exu_alu_stage.sv
// Self-checking bench for ysyx_23060229_exu_alu_stage.
// Directed vector table plus handshake/flush/reset sequences.

module tb_ysyx_23060229_exu_alu_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  out_rd;

  int tests;
  int fails;

  ysyx_23060229_exu_alu_stage #(
    .XLEN(32),
    .RD_W(5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .src1     (src1),
    .src2     (src2),
    .rd       (rd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .out_rd   (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_vec(input int i);
    int  n;
    bit  single;
    @(negedge clk);
    op        = vecs[i].op;
    src1      = vecs[i].a;
    src2      = vecs[i].b;
    rd        = vecs[i].rd;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(n);
    single = 1'b1;
`ifdef YSYX_23060229_EXU_SERIAL_SHIFT_EN
    if ((vecs[i].op == 4'd2 || vecs[i].op == 4'd6 || vecs[i].op == 4'd7)
        && vecs[i].b[4:0] != 5'd0)
      single = 1'b0;
`endif
    check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
    if (single)
      check($sformatf("vec%0d latency", i), n, 32'd1);
    check($sformatf("vec%0d result", i), result, vecs[i].exp);
    check($sformatf("vec%0d out_rd", i), {27'd0, out_rd},
          {27'd0, vecs[i].rd});
  endtask

  initial begin
    int n;
    int seen;
    tests = 0;
    fails = 0;

    vecs[0]  = '{4'd0,  32'h00000003, 32'h00000004, 5'd1,  32'h00000007};
    vecs[1]  = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 5'd2,  32'h00000000};
    vecs[2]  = '{4'd1,  32'h00000000, 32'h00000001, 5'd3,  32'hFFFFFFFF};
    vecs[3]  = '{4'd2,  32'h00000001, 32'h0000001F, 5'd4,  32'h80000000};
    vecs[4]  = '{4'd2,  32'h12345678, 32'h00000004, 5'd5,  32'h23456780};
    vecs[5]  = '{4'd3,  32'hFFFFFFFF, 32'h00000001, 5'd6,  32'h00000001};
    vecs[6]  = '{4'd3,  32'h00000001, 32'hFFFFFFFF, 5'd7,  32'h00000000};
    vecs[7]  = '{4'd4,  32'hFFFFFFFF, 32'h00000001, 5'd8,  32'h00000000};
    vecs[8]  = '{4'd4,  32'h00000001, 32'hFFFFFFFF, 5'd9,  32'h00000001};
    vecs[9]  = '{4'd5,  32'h000000F0, 32'h000000FF, 5'd10, 32'h0000000F};
    vecs[10] = '{4'd6,  32'h80000000, 32'h00000004, 5'd11, 32'h08000000};
    vecs[11] = '{4'd7,  32'h80000000, 32'h00000004, 5'd12, 32'hF8000000};
    vecs[12] = '{4'd7,  32'h7FFFFFF0, 32'h00000024, 5'd13, 32'h07FFFFFF};
    vecs[13] = '{4'd7,  32'h80000001, 32'h00000000, 5'd14, 32'h80000001};
    vecs[14] = '{4'd7,  32'h80000000, 32'h0000001F, 5'd15, 32'hFFFFFFFF};
    vecs[15] = '{4'd8,  32'h0000F0F0, 32'h00000F00, 5'd16, 32'h0000FFF0};
    vecs[16] = '{4'd9,  32'hFF00FF00, 32'h0FF00FF0, 5'd17, 32'h0F000F00};
    vecs[17] = '{4'd10, 32'hAAAAAAAA, 32'h12345000, 5'd18, 32'h12345000};
    vecs[18] = '{4'd11, 32'h00000005, 32'h00000006, 5'd19, 32'h00000000};
    vecs[19] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd20, 32'h00000000};
    vecs[20] = '{4'd6,  32'hF0000000, 32'h00000000, 5'd21, 32'hF0000000};

    // Reset held with a valid op on the inputs
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    op        = 4'd0;
    src1      = 32'd5;
    src2      = 32'd6;
    rd        = 5'd9;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst out_rd", {27'd0, out_rd}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    check("post-rst idle", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 21; i++) run_vec(i);

    // Drain, then backpressure: ADD 3+4 rd=7 held for 5 cycles
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    op        = 4'd0;
    src1      = 32'd3;
    src2      = 32'd4;
    rd        = 5'd7;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d out_valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d result", c), result, 32'd7);
      check($sformatf("bp%0d out_rd", c), {27'd0, out_rd}, 32'd7);
      check($sformatf("bp%0d in_ready", c), {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    // Accept while draining: XOR 0xF0 ^ 0xFF
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    op        = 4'd5;
    src1      = 32'h000000F0;
    src2      = 32'h000000FF;
    rd        = 5'd3;
    #1;
    check("drain in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("nobubble out_valid", {31'd0, out_valid}, 32'd1);
    check("nobubble result", result, 32'h0000000F);
    check("nobubble out_rd", {27'd0, out_rd}, 32'd3);
    @(posedge clk);
    #1;
    check("drained out_valid", {31'd0, out_valid}, 32'd0);

    // Flush in HOLD with in_valid and out_ready high
    @(negedge clk);
    op        = 4'd0;
    src1      = 32'd10;
    src2      = 32'd20;
    rd        = 5'd11;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre-flush result", result, 32'd30);
    @(negedge clk);
    flush     = 1'b1;
    out_ready = 1'b1;
    op        = 4'd10;
    src2      = 32'h0000DEAD;
    rd        = 5'd22;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    check("flush result kept", result, 32'd30);
    check("flush out_rd kept", {27'd0, out_rd}, 32'd11);
    check("flush idle in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    check("flush no accept", {31'd0, out_valid}, 32'd0);

`ifdef YSYX_23060229_EXU_SERIAL_SHIFT_EN
    // SLL 1<<31: out_valid exactly 32 edges after accept
    @(negedge clk);
    op       = 4'd2;
    src1     = 32'd1;
    src2     = 32'd31;
    rd       = 5'd4;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("ser in_ready busy", {31'd0, in_ready}, 32'd0);
    wait_valid(n);
    check("ser latency", n, 32'd32);
    check("ser result", result, 32'h80000000);
    check("ser out_rd", {27'd0, out_rd}, 32'd4);

    // Flush at cycle 10 of a shift
    @(negedge clk);
    op       = 4'd6;
    src1     = 32'hFFFFFFFF;
    src2     = 32'd20;
    rd       = 5'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("serflush in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    check("serflush never valid", seen, 32'd0);

    // Reset pulse mid-shift
    @(negedge clk);
    op       = 4'd7;
    src1     = 32'h80000000;
    src2     = 32'd25;
    rd       = 5'd6;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("serrst out_valid", {31'd0, out_valid}, 32'd0);
    check("serrst result", result, 32'd0);
    check("serrst out_rd", {27'd0, out_rd}, 32'd0);
    check("serrst in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Async reset pulse while holding a result
    @(negedge clk);
    op        = 4'd0;
    src1      = 32'd1;
    src2      = 32'd2;
    rd        = 5'd12;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("hold before rst", result, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst out_valid", {31'd0, out_valid}, 32'd0);
    check("arst result", result, 32'd0);
    check("arst out_rd", {27'd0, out_rd}, 32'd0);
    check("arst in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_23060229_exu_alu_stage.md
Name: ysyx_23060229_exu_alu_stage

Overview:
- Execute-stage ALU slot between decode (IDU) and writeback/LSU.
- Takes decoded operands over a valid/ready handshake and computes the RV32I integer ALU result, including logical and arithmetic right shifts.
- Holds the result in an output register until downstream accepts it.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RD_W, 5, destination-register index width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous pipeline flush.
in_valid  in  1  upstream operation valid.
in_ready  out  1  stage can accept an operation this cycle.
op  in  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS2 (LUI); 11-15 reserved.
src1  in  XLEN  operand 1.
src2  in  XLEN  operand 2; shift amount is src2[4:0].
rd  in  RD_W  destination register tag.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
result  out  XLEN  registered ALU result.
out_rd  out  RD_W  registered rd tag.

Behaviour:
- States: IDLE (empty), SHIFT (serial shift in progress, macro builds only), HOLD (result valid).
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - out_valid = 0, result = 0, out_rd = 0, shift counter = 0.
  - in_ready is 1 while reset is held.
- in_ready = (state == IDLE) || (state == HOLD && out_ready). This is combinational and allows accept-while-draining.
- Accept occurs on a rising edge where in_valid && in_ready && !flush.
  - src1, src2, op and rd are captured.
  - Non-serial ops: result is written and the state moves to HOLD on that edge. out_valid is high in the following cycle (1-cycle latency).
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^32.
  - SLT is a signed compare; SLTU is unsigned. Both give 0 or 1.
  - SLL/SRL shift by src2[4:0].
  - SRA fills vacated bits with src1[31]. A shift amount of 0 returns src1 unchanged.
  - PASS2 gives result = src2.
  - Reserved ops give result = 0 and still complete normally.
- HOLD:
  - result and out_rd are stable while out_valid && !out_ready.
  - If out_ready is high and nothing is accepted, go to IDLE and drop out_valid.
  - If out_ready and an accept happen on the same edge, the new op is loaded directly. out_valid stays 1 for a single-cycle op.
- flush dominates every other input on its edge:
  - State goes to IDLE, out_valid = 0, nothing is accepted.
  - result and out_rd keep their old values.
- The reset value is restored immediately on rst_n assertion in any state, including mid-shift.

Optional Feature:
Macro YSYX_23060229_EXU_SERIAL_SHIFT_EN.
- Defined: SLL, SRL and SRA use a 1-bit-per-cycle iterative shifter instead of a barrel shifter.
  - On accept with shamt k > 0: load a working register with src1 and set counter = k. Go to SHIFT with out_valid = 0 and in_ready = 0.
  - Each SHIFT cycle shifts the working register by one bit (SRA replicates bit 31) and decrements the counter.
  - When the counter reaches 0, write result and go to HOLD. out_valid rises k+1 edges after accept.
  - shamt = 0 completes like a single-cycle op.
  - flush in SHIFT aborts to IDLE.
- Undefined: the SHIFT state and counter are absent, and every op has 1-cycle latency.

Test Plan:
- Reset:
  - Hold rst_n low, drive in_valid = 1 -> out_valid = 0, result = 0, out_rd = 0, in_ready = 1.
  - Release rst_n -> the first accept produces out_valid in the next cycle.
- Arithmetic:
  - SRA src1 = 0x80000000, src2 = 4 -> result = 0xF8000000.
  - SRL with the same operands -> 0x08000000.
  - SRA src1 = 0x7FFFFFF0, src2 = 0x24 (shamt 4) -> 0x07FFFFFF.
- Compares:
  - SLT src1 = 0xFFFFFFFF, src2 = 1 -> 1.
  - SLTU with the same operands -> 0.
  - SUB 0 - 1 -> 0xFFFFFFFF.
- Backpressure:
  - ADD 3 + 4 with rd = 7, out_ready = 0 for 5 cycles -> result = 7, out_rd = 7 stable, in_ready = 0.
  - Then assert out_ready together with a new in_valid XOR 0xF0 ^ 0xFF -> next cycle result = 0x0F with no bubble.
- Flush:
  - Flush in HOLD with in_valid high -> next cycle out_valid = 0, nothing accepted, state IDLE.
- Serial shift (macro defined):
  - SLL 1 << 31 -> out_valid exactly 32 edges after accept, result = 0x80000000.
  - A flush at cycle 10 of the shift -> IDLE, out_valid never asserted.
  - rst_n pulsed mid-shift -> all outputs return to 0 asynchronously.
